// File: rtl/instruction_decoder.sv
// -----------------------------------------------------------------------------
// instruction_decoder
//
// Registered decode stage of the 16-bit mini MIPS datapath. It sits between the
// instruction memory fetch and the register file / ALU. Each valid instruction
// word is split into its fixed bit fields. The stage also produces:
//   - the sign-extended immediate,
//   - the destination register index,
//   - the main control flags.
// All of these appear one cycle after the capture edge.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears every output including out_valid
//   in_valid     instruction is valid this cycle
//   instruction  raw 16-bit instruction word
//   out_valid    decoded outputs are valid
//   opcode       instruction[15:12]
//   rs           instruction[11:9]
//   rt           instruction[8:6]
//   rd           instruction[5:3]
//   func         instruction[2:0]
//   imm          instruction[5:0]
//   imm_ext      imm sign-extended to 16 bits
//   write_reg    destination register (rd for R-type, rt otherwise)
//   is_rtype     opcode == 0000
//   reg_write    instruction writes the register file
//   alu_src      ALU B operand is imm_ext
//   mem_read     load
//   mem_write    store
//   branch_eq    beq
//   branch_ne    bne
//   illegal      opcode outside the defined map (1001..1111)
// -----------------------------------------------------------------------------
module instruction_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [15:0] instruction,
   output logic        out_valid,
   output logic [3:0]  opcode,
   output logic [2:0]  rs,
   output logic [2:0]  rt,
   output logic [2:0]  rd,
   output logic [2:0]  func,
   output logic [5:0]  imm,
   output logic [15:0] imm_ext,
   output logic [2:0]  write_reg,
   output logic        is_rtype,
   output logic        reg_write,
   output logic        alu_src,
   output logic        mem_read,
   output logic        mem_write,
   output logic        branch_eq,
   output logic        branch_ne,
   output logic        illegal
);

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0001;
   localparam logic [3:0] OP_ANDI  = 4'b0010;
   localparam logic [3:0] OP_ORI   = 4'b0011;
   localparam logic [3:0] OP_SLTI  = 4'b0100;
   localparam logic [3:0] OP_LW    = 4'b0101;
   localparam logic [3:0] OP_SW    = 4'b0110;
   localparam logic [3:0] OP_BEQ   = 4'b0111;
   localparam logic [3:0] OP_BNE   = 4'b1000;

   typedef struct packed {
      logic is_rtype;
      logic reg_write;
      logic alu_src;
      logic mem_read;
      logic mem_write;
      logic branch_eq;
      logic branch_ne;
      logic illegal;
   } ctrl_t;

   // Control flags from the opcode alone. Any opcode outside the map raises
   // only the illegal flag, so a bad word can never write state.
   function automatic ctrl_t decode_ctrl(input logic [3:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.is_rtype  = 1'b1;
            c.reg_write = 1'b1;
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
         end
         OP_LW: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
            c.mem_read  = 1'b1;
         end
         OP_SW: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         OP_BEQ:  c.branch_eq = 1'b1;
         OP_BNE:  c.branch_ne = 1'b1;
         default: c.illegal   = 1'b1;
      endcase
      return c;
   endfunction

   function automatic logic signed [15:0] sign_ext_imm(input logic signed [5:0] im);
      return {{10{im[5]}}, im};
   endfunction

   // ---- stage p0: combinational decode of the incoming word ----
   logic [3:0]         opcode_p0;
   logic [2:0]         rs_p0;
   logic [2:0]         rt_p0;
   logic [2:0]         rd_p0;
   logic [2:0]         func_p0;
   logic signed [5:0]  imm_p0;
   logic signed [15:0] imm_ext_p0;
   logic [2:0]         write_reg_p0;
   ctrl_t              ctrl_p0;

   always_comb begin
      opcode_p0    = instruction[15:12];
      rs_p0        = instruction[11:9];
      rt_p0        = instruction[8:6];
      rd_p0        = instruction[5:3];
      func_p0      = instruction[2:0];
      imm_p0       = instruction[5:0];
      imm_ext_p0   = sign_ext_imm(imm_p0);
      ctrl_p0      = decode_ctrl(opcode_p0);
      write_reg_p0 = ctrl_p0.is_rtype ? rd_p0 : rt_p0;
   end

   // ---- stage p1: output registers ----
   // Reset clears data as well as valid because downstream logic sees the
   // outputs directly. Idle cycles drop only the valid flag and hold the last decode.
   logic               vld_p1;
   logic [3:0]         opcode_p1;
   logic [2:0]         rs_p1;
   logic [2:0]         rt_p1;
   logic [2:0]         rd_p1;
   logic [2:0]         func_p1;
   logic signed [5:0]  imm_p1;
   logic signed [15:0] imm_ext_p1;
   logic [2:0]         write_reg_p1;
   ctrl_t              ctrl_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1       <= 1'b0;
         opcode_p1    <= '0;
         rs_p1        <= '0;
         rt_p1        <= '0;
         rd_p1        <= '0;
         func_p1      <= '0;
         imm_p1       <= '0;
         imm_ext_p1   <= '0;
         write_reg_p1 <= '0;
         ctrl_p1      <= '0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            opcode_p1    <= opcode_p0;
            rs_p1        <= rs_p0;
            rt_p1        <= rt_p0;
            rd_p1        <= rd_p0;
            func_p1      <= func_p0;
            imm_p1       <= imm_p0;
            imm_ext_p1   <= imm_ext_p0;
            write_reg_p1 <= write_reg_p0;
            ctrl_p1      <= ctrl_p0;
         end
      end
   end

   assign out_valid = vld_p1;
   assign opcode    = opcode_p1;
   assign rs        = rs_p1;
   assign rt        = rt_p1;
   assign rd        = rd_p1;
   assign func      = func_p1;
   assign imm       = imm_p1;
   assign imm_ext   = imm_ext_p1;
   assign write_reg = write_reg_p1;
   assign is_rtype  = ctrl_p1.is_rtype;
   assign reg_write = ctrl_p1.reg_write;
   assign alu_src   = ctrl_p1.alu_src;
   assign mem_read  = ctrl_p1.mem_read;
   assign mem_write = ctrl_p1.mem_write;
   assign branch_eq = ctrl_p1.branch_eq;
   assign branch_ne = ctrl_p1.branch_ne;
   assign illegal   = ctrl_p1.illegal;

endmodule

// File: tb/tb_instruction_decoder.sv
// -----------------------------------------------------------------------------
// tb_instruction_decoder
//
// Self-checking bench for instruction_decoder. The reference model derives
// every field arithmetically from the instruction word. It takes the control
// flags from a per-opcode table, and it tracks the held outputs across idle
// and reset cycles.
// -----------------------------------------------------------------------------
module tb_instruction_decoder;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [15:0] instruction;
   logic        out_valid;
   logic [3:0]  opcode;
   logic [2:0]  rs, rt, rd, func, write_reg;
   logic [5:0]  imm;
   logic [15:0] imm_ext;
   logic        is_rtype, reg_write, alu_src, mem_read, mem_write;
   logic        branch_eq, branch_ne, illegal;

   int errors = 0;
   int checks = 0;

   instruction_decoder dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
      .out_valid(out_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
      .func(func), .imm(imm), .imm_ext(imm_ext), .write_reg(write_reg),
      .is_rtype(is_rtype), .reg_write(reg_write), .alu_src(alu_src),
      .mem_read(mem_read), .mem_write(mem_write), .branch_eq(branch_eq),
      .branch_ne(branch_ne), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view of every output, in a fixed order used by the model.
   logic [49:0] act;
   assign act = {out_valid, opcode, rs, rt, rd, func, imm, imm_ext, write_reg,
                 is_rtype, reg_write, alu_src, mem_read, mem_write,
                 branch_eq, branch_ne, illegal};

   // reg_write / alu_src / mem_read / mem_write / branch_eq / branch_ne per opcode 0..8
   logic [5:0] ctrl_tbl [9] = '{6'b100000, 6'b110000, 6'b110000, 6'b110000,
                                6'b110000, 6'b111000, 6'b010100, 6'b000010,
                                6'b000001};

   logic [49:0] exp_state = '0;

   function automatic logic [49:0] model_decode(input logic [15:0] ins);
      int w, op, rsv, rtv, rdv, fn, im, ext, wr;
      logic [5:0] fl;
      logic isr, ill;
      w   = int'(ins);
      op  = w / 4096;
      rsv = (w / 512) % 8;
      rtv = (w / 64) % 8;
      rdv = (w / 8) % 8;
      fn  = w % 8;
      im  = w % 64;
      ext = (im >= 32) ? im + 65536 - 64 : im;
      isr = (op == 0);
      ill = (op > 8);
      fl  = ill ? 6'b000000 : ctrl_tbl[op];
      wr  = isr ? rdv : rtv;
      return {1'b1, 4'(op), 3'(rsv), 3'(rtv), 3'(rdv), 3'(fn), 6'(im), 16'(ext),
              3'(wr), isr, fl, ill};
   endfunction

   // Drive one cycle, then advance the reference state to match the edge.
   task automatic cycle(input logic r, input logic v, input logic [15:0] ins);
      reset       = r;
      in_valid    = v;
      instruction = ins;
      @(posedge clk);
      #1;
      if (r)      exp_state = '0;
      else if (v) exp_state = model_decode(ins);
      else        exp_state[49] = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b1, 16'hFFFF);
         checks++;
         if (act !== 50'd0) begin
            errors++;
            $display("FAIL reset_clear: got %h expected 0", act);
         end
      end
      cycle(1'b0, 1'b1, 16'hFFFF);
      checks++;
      if (out_valid !== 1'b1 || opcode !== 4'b1111 || illegal !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got valid=%b op=%b ill=%b expected 1 1111 1",
                  out_valid, opcode, illegal);
      end
      checks++;
      if (act !== exp_state) begin
         errors++;
         $display("FAIL reset_release_all: got %h expected %h", act, exp_state);
      end
   endtask

   task automatic test_rtype();
      logic [15:0] ins [4] = '{16'b0000000001010000, 16'b0000001010011001,
                               16'b0000010011100010, 16'b0000011100101011};
      // {opcode, rs, rt, rd, func, imm}
      logic [21:0] fld [4] = '{{4'b0000, 3'b000, 3'b001, 3'b010, 3'b000, 6'b010000},
                               {4'b0000, 3'b001, 3'b010, 3'b011, 3'b001, 6'b011001},
                               {4'b0000, 3'b010, 3'b011, 3'b100, 3'b010, 6'b100010},
                               {4'b0000, 3'b011, 3'b100, 3'b101, 3'b011, 6'b101011}};
      logic [21:0] f;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, ins[i]);
         f = fld[i];
         checks++;
         if ({opcode, rs, rt, rd, func, imm} !== f) begin
            errors++;
            $display("FAIL rtype_fields[%0d]: got %h expected %h", i,
                     {opcode, rs, rt, rd, func, imm}, f);
         end
         checks++;
         if (is_rtype !== 1'b1 || reg_write !== 1'b1 || write_reg !== f[11:9]) begin
            errors++;
            $display("FAIL rtype_ctrl[%0d]: got rtype=%b rw=%b wr=%b expected 1 1 %b",
                     i, is_rtype, reg_write, write_reg, f[11:9]);
         end
         checks++;
         if (act !== exp_state) begin
            errors++;
            $display("FAIL rtype_all[%0d]: got %h expected %h", i, act, exp_state);
         end
      end
   endtask

   task automatic test_immediate();
      cycle(1'b0, 1'b1, 16'b0001_001_010_111111);
      checks++;
      if (imm !== 6'b111111 || imm_ext !== 16'hFFFF || write_reg !== 3'b010 ||
          alu_src !== 1'b1) begin
         errors++;
         $display("FAIL imm_neg: got imm=%b ext=%h wr=%b src=%b expected 111111 ffff 010 1",
                  imm, imm_ext, write_reg, alu_src);
      end
      cycle(1'b0, 1'b1, 16'b0001_001_010_011111);
      checks++;
      if (imm_ext !== 16'h001F) begin
         errors++;
         $display("FAIL imm_pos: got %h expected 001f", imm_ext);
      end
      checks++;
      if (act !== exp_state) begin
         errors++;
         $display("FAIL imm_all: got %h expected %h", act, exp_state);
      end
   endtask

   task automatic test_mem_branch();
      logic [15:0] ins [4] = '{16'h5A8C, 16'h6B17, 16'h7250, 16'h8FC3};
      // reg_write alu_src mem_read mem_write branch_eq branch_ne
      logic [5:0]  flg [4] = '{6'b111000, 6'b010100, 6'b000010, 6'b000001};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, ins[i]);
         checks++;
         if ({reg_write, alu_src, mem_read, mem_write, branch_eq, branch_ne, is_rtype,
              illegal} !== {flg[i], 2'b00}) begin
            errors++;
            $display("FAIL membr_flags[%0d]: got %b expected %b", i,
                     {reg_write, alu_src, mem_read, mem_write, branch_eq, branch_ne,
                      is_rtype, illegal}, {flg[i], 2'b00});
         end
         checks++;
         if (act !== exp_state) begin
            errors++;
            $display("FAIL membr_all[%0d]: got %h expected %h", i, act, exp_state);
         end
      end
   endtask

   task automatic test_hold();
      logic [49:0] held;
      held = model_decode(16'h1234);
      cycle(1'b0, 1'b1, 16'h1234);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 16'($urandom));
         checks++;
         if (out_valid !== 1'b0 || act[48:0] !== held[48:0]) begin
            errors++;
            $display("FAIL hold[%0d]: got %h expected %h", i, act, {1'b0, held[48:0]});
         end
      end
   endtask

   task automatic test_illegal();
      logic [15:0] ins;
      for (int op = 0; op < 16; op++) begin
         ins = {4'(op), 12'($urandom)};
         cycle(1'b0, 1'b1, ins);
         checks++;
         if (illegal !== (op > 8)) begin
            errors++;
            $display("FAIL illegal_flag[op=%0d]: got %b expected %b", op, illegal, op > 8);
         end
         if (op > 8) begin
            checks++;
            if ({is_rtype, reg_write, alu_src, mem_read, mem_write, branch_eq,
                 branch_ne} !== 7'd0) begin
               errors++;
               $display("FAIL illegal_ctrl[op=%0d]: got %b expected 0000000", op,
                        {is_rtype, reg_write, alu_src, mem_read, mem_write,
                         branch_eq, branch_ne});
            end
         end
         checks++;
         if (act !== exp_state) begin
            errors++;
            $display("FAIL illegal_all[op=%0d]: got %h expected %h", op, act, exp_state);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic r, v;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 19) == 0);
         v = ($urandom_range(0, 3) != 0);
         cycle(r, v, 16'($urandom));
         checks++;
         if (act !== exp_state) begin
            errors++;
            $display("FAIL random[%0d]: got %h expected %h", i, act, exp_state);
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      instruction = 16'h0000;
      test_reset();
      test_rtype();
      test_immediate();
      test_mem_branch();
      test_hold();
      test_illegal();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
